// File: rtl/mem_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge_pkg
// Brief    : Shared state encoding and default widths for the CPU memory
//            bridge; ERR exists only when MEM_BRIDGE_TIMEOUT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bridge_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
`ifdef MEM_BRIDGE_TIMEOUT_EN
    , ERR = 2'd3
`endif
  } memif_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_bridge
// Brief    : Turns CPU level read/write strobes into one handshaked external
//            access per rising edge. MEM_BRIDGE_TIMEOUT_EN adds an abort path.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              bus_err,
  output logic              ext_req,
  output logic              ext_we,
  output logic [ADDR_W-1:0] ext_addr,
  output logic [DATA_W-1:0] ext_wdata,
  input  logic [DATA_W-1:0] ext_rdata,
  input  logic              ext_ack
);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("mem_bridge: TIMEOUT_CYC must be at least 1");
  end

  memif_state_t r_state;
  logic         r_strobe_q;
  logic         w_strobe;
  logic         w_start;

  assign w_strobe = mem_rd | mem_wr;
  // Only a fresh rise seen in IDLE opens an access; a held level never retriggers.
  assign w_start  = w_strobe & ~r_strobe_q & (r_state == IDLE);

`ifdef MEM_BRIDGE_TIMEOUT_EN
  localparam int               c_cnt_w    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_bus_err;

  assign stall   = w_start | (r_state == REQ) | (r_state == ERR);
  assign bus_err = r_bus_err;
`else
  assign stall   = w_start | (r_state == REQ);
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_strobe_q <= 1'b0;
      rdata      <= '0;
      ext_req    <= 1'b0;
      ext_we     <= 1'b0;
      ext_addr   <= '0;
      ext_wdata  <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      r_cnt      <= '0;
      r_bus_err  <= 1'b0;
`endif
    end else begin
      r_strobe_q <= w_strobe;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state   <= REQ;
            ext_req   <= 1'b1;
            ext_addr  <= addr;
            ext_wdata <= wdata;
            // Simultaneous rd+wr resolves to a write.
            ext_we    <= mem_wr;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        REQ: begin
          // Ack wins over a timeout landing in the same cycle.
          if (ext_ack) begin
            r_state <= DONE;
            ext_req <= 1'b0;
            if (!ext_we) begin
              rdata <= ext_rdata;
            end
          end
`ifdef MEM_BRIDGE_TIMEOUT_EN
          else if (r_cnt == c_cnt_last) begin
            r_state   <= ERR;
            ext_req   <= 1'b0;
            r_bus_err <= 1'b1;
            if (!ext_we) begin
              rdata <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        DONE: begin
          r_state <= IDLE;
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        ERR: begin
          r_state <= DONE;
        end
`endif
        default: begin
          r_state <= IDLE;
          ext_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width.
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter TIMEOUT_CYC, default 15, maximum number of REQ-state cycles without ext_ack before an access is aborted.
REQ-004 Port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port mem_rd  input  1  level read strobe from the CPU controller.
REQ-007 Port mem_wr  input  1  level write strobe from the CPU controller.
REQ-008 Port addr  input  ADDR_W  access address from the CPU address mux.
REQ-009 Port wdata  input  DATA_W  write data from the accumulator.
REQ-010 Port rdata  output  DATA_W  registered read data returned to the CPU.
REQ-011 Port stall  output  1  high while an access is outstanding.
REQ-012 Port bus_err  output  1  sticky flag for an aborted access.
REQ-013 Port ext_req  output  1  external memory request.
REQ-014 Port ext_we  output  1  external write enable, valid while ext_req is high.
REQ-015 Port ext_addr  output  ADDR_W  latched address.
REQ-016 Port ext_wdata  output  DATA_W  latched write data.
REQ-017 Port ext_rdata  input  DATA_W  external read data, valid with ext_ack.
REQ-018 Port ext_ack  input  1  external completion, single-cycle pulse.

Function
REQ-019 The bridge SHALL detect a start as a 0->1 transition of (mem_rd|mem_wr) versus the value registered on the previous cycle; a level held high SHALL NOT start a second access.
REQ-020 The FSM states SHALL be IDLE, REQ, DONE and ERR.
REQ-021 IDLE->REQ on a start: latch addr into ext_addr, wdata into ext_wdata, and ext_we=mem_wr.
REQ-022 If mem_rd and mem_wr both rise in the same cycle, the bridge SHALL perform a write only and SHALL NOT set bus_err.
REQ-023 ext_req SHALL be 1 exactly while the state is REQ.
REQ-024 REQ->DONE on ext_ack; on a read ack, rdata SHALL capture ext_rdata on the same edge; on a write ack, rdata SHALL hold.
REQ-025 DONE->IDLE unconditionally after one cycle.
REQ-026 stall SHALL be combinationally high in the start cycle and while the state is REQ or ERR, and SHALL be low in DONE and otherwise in IDLE.
REQ-027 Latency: with ext_ack in the first REQ cycle, stall SHALL be high for exactly 2 cycles.
REQ-028 ext_ack outside REQ SHALL be ignored.
REQ-029 Strobe deassertion during REQ SHALL NOT abort the access.
REQ-030 ext_addr, ext_wdata and ext_we SHALL stay stable from IDLE->REQ until leaving REQ.

Reset
REQ-031 On reset, at the next edge: state=IDLE, rdata=0, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, bus_err=0, timeout counter=0, strobe history=0.
REQ-032 Reset during REQ SHALL drop ext_req on that edge, and an ext_ack in the same cycle SHALL be ignored.

Configuration
REQ-033 With macro MEM_BRIDGE_TIMEOUT_EN defined: a counter SHALL clear on entry to REQ and increment on each REQ cycle without ack; on reaching TIMEOUT_CYC, REQ->ERR.
REQ-034 On entering ERR, bus_err SHALL be set sticky until reset, and rdata SHALL be cleared to 0 if the access was a read.
REQ-035 ERR SHALL go to DONE after one cycle.
REQ-036 Ack precedence: an ext_ack in the same cycle the count reaches TIMEOUT_CYC SHALL complete the access normally.
REQ-037 Without MEM_BRIDGE_TIMEOUT_EN: no counter and no ERR state exist, REQ waits indefinitely, and bus_err SHALL be tied to 0.

Structure
REQ-038 The shared typedefs package SHALL hold the enum memif_state_t and the constants ADDR_W_DEF=5 and DATA_W_DEF=8.
REQ-039 The design SHALL be a single module with no sub-module; the edge detect and counter are inline.

Verification
REQ-040 Read: mem_rd rises, addr=5'h0A, ext_ack in the 1st REQ cycle with ext_rdata=8'h3C -> ext_addr=0A, ext_we=0, rdata=3C after DONE, stall high 2 cycles.
REQ-041 Write with wait: mem_wr rises, wdata=8'h55, ext_ack after 4 REQ cycles -> ext_we=1, ext_wdata=55 stable throughout, stall high 5 cycles, rdata unchanged.
REQ-042 Held strobe: mem_rd held high 6 cycles -> exactly one ext_req assertion.
REQ-043 Both strobes: mem_rd and mem_wr rise together -> single write, bus_err=0.
REQ-044 Timeout, macro on: no ext_ack -> ERR after 15 REQ cycles, bus_err=1 sticky, rdata=0; ext_ack arriving on cycle 15 -> normal completion.
REQ-045 Reset mid-REQ: reset in the 2nd REQ cycle -> ext_req=0 and stall=0 next cycle, and a late ext_ack leaves rdata=0.
